// File: rtl/bn_res_pkg.sv
// bn_res_pkg: shared widths, sample type and saturation helper
// for the layer-7 batch-norm / residual-add stage.
package bn_res_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int PROD_WIDTH = 32;
  localparam int SUM_WIDTH  = 26;
  localparam int SCL_WIDTH  = PROD_WIDTH - FRAC_BITS;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic signed [PROD_WIDTH-1:0] prod_t;
  typedef logic signed [SCL_WIDTH-1:0]  scaled_t;
  typedef logic signed [SUM_WIDTH-1:0]  sum_t;

  localparam sample_t K_ONE = sample_t'(1 << FRAC_BITS);
  localparam sum_t    S_MAX = sum_t'(32767);
  localparam sum_t    S_MIN = sum_t'(-32768);

  function automatic sample_t sat16(input sum_t x);
    if (x > S_MAX) return sample_t'(16'h7fff);
    if (x < S_MIN) return sample_t'(16'h8000);
    return sample_t'(x[DATA_WIDTH-1:0]);
  endfunction

endpackage

// File: rtl/res_fifo.sv
// res_fifo: in-order residual vector buffer with empty-cycle
// bypass, flush, and drop/underflow strobes.
module res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2048
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         push_drop_o,
  output logic         pop_empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty, full, bypass;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign bypass  = push_i & pop_i & empty;
  assign do_push = push_i & ~bypass & (~full | pop_i);
  assign do_pop  = pop_i & ~empty;

  assign push_drop_o = push_i & full & ~pop_i;
  assign pop_empty_o = pop_i & empty & ~push_i;

  // Empty pop yields the bypassed input, or zero with no push
  assign dout_o = !empty ? mem_q[rd_q]
                : (push_i ? din_i : '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/bn_res_layer7.sv
// bn_res_layer7: per-channel scale/bias plus residual add,
// two-stage pipeline with saturation to 16 bits.
module bn_res_layer7
  import bn_res_pkg::*;
#(
  parameter int FM_DEPTH       = 128,
  parameter int RES_FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                mode,
  input  logic                                vs_in,
  input  logic                                res_e,
  input  logic [FM_DEPTH-1:0][DATA_WIDTH-1:0] res,
  input  logic                                conv_e,
  input  logic [FM_DEPTH-1:0][DATA_WIDTH-1:0] conv_in,
  input  logic                                param_we,
  input  logic [$clog2(FM_DEPTH)-1:0]         param_ch,
  input  sample_t                             param_k,
  input  sample_t                             param_b,
  output logic [FM_DEPTH-1:0][DATA_WIDTH-1:0] data_out,
  output logic                                data_e_out,
  output logic                                vs_out,
  output logic                                ovf_err,
  output logic                                unf_err
);

  localparam int VW = FM_DEPTH * DATA_WIDTH;

  sample_t k_q [FM_DEPTH];
  sample_t b_q [FM_DEPTH];
  scaled_t scl_d [FM_DEPTH];
  scaled_t scl_q [FM_DEPTH];
  sample_t r_q [FM_DEPTH];
  sample_t y_d [FM_DEPTH];
  sample_t data_q [FM_DEPTH];

  logic [FM_DEPTH-1:0][DATA_WIDTH-1:0] res_pop;
  logic push, pop, drop, pop_empty, adv;
  logic v1_q, de_q, vs1_q, vs2_q, ovf_q, unf_q;

  // A frame start overrides any same-cycle push or pop
  assign push = res_e & mode & ~vs_in;
  assign pop  = conv_e & mode & ~vs_in;
  assign adv  = v1_q & mode & ~vs_in;

  res_fifo #(
    .DEPTH (RES_FIFO_DEPTH),
    .W     (VW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (vs_in),
    .push_i      (push),
    .pop_i       (pop),
    .din_i       (res),
    .dout_o      (res_pop),
    .push_drop_o (drop),
    .pop_empty_o (pop_empty)
  );

  for (genvar i = 0; i < FM_DEPTH; i++) begin : g_ch
    prod_t prod;
    sum_t  sum;
    assign prod = prod_t'($signed(conv_in[i]))
                * prod_t'(k_q[i]);
    assign scl_d[i] = scaled_t'(prod >>> FRAC_BITS);
    assign sum = sum_t'(scl_q[i])
               + sum_t'(b_q[i])
               + sum_t'(r_q[i]);
    assign y_d[i] = sat16(sum);
    assign data_out[i] = data_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FM_DEPTH; i++) begin
        k_q[i] <= K_ONE;
        b_q[i] <= '0;
      end
    end else if (!mode && param_we) begin
      k_q[param_ch] <= param_k;
      b_q[param_ch] <= param_b;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < FM_DEPTH; i++) begin
        scl_q[i] <= scl_d[i];
        r_q[i]   <= sample_t'(res_pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      de_q  <= 1'b0;
      vs1_q <= 1'b0;
      vs2_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < FM_DEPTH; i++)
        data_q[i] <= '0;
    end else begin
      v1_q  <= pop;
      de_q  <= adv;
      vs1_q <= vs_in;
      vs2_q <= vs1_q;
      ovf_q <= ovf_q | drop;
      unf_q <= unf_q | pop_empty;
      if (adv) begin
        for (int i = 0; i < FM_DEPTH; i++)
          data_q[i] <= y_d[i];
      end
    end
  end

  assign data_e_out = de_q;
  assign vs_out     = vs2_q;
  assign ovf_err    = ovf_q;
  assign unf_err    = unf_q;

endmodule

// File: doc/bn_res_layer7.md
# bn_res_layer7

Per-channel batch-norm and residual-add stage for layer 7. It sits directly downstream of the layer-7 window/pooling wrapper and of the macro decoder. It buffers the 2x2-pooled residual vectors produced by the wrapper, pairs each one in order with the matching decoded convolution vector, and applies `out = sat16(((conv * k) >>> FRAC_BITS) + b + res)` per channel. The result, with its `data_e` and `vs` strobes, drives the next layer's input.

## Interface
- `FM_DEPTH`, 128, number of channels processed in parallel
- `DATA_WIDTH`, 16, sample width, matching the codebase `DATA_WIDTH` define
- `FRAC_BITS`, 8, fractional bits of the scale `k`
- `RES_FIFO_DEPTH`, 4, number of residual vectors buffered (power of 2)

Ports:
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  reset: synchronous, active-high
- `mode`  in  1  0 = reload parameters, 1 = calculate
- `vs_in`  in  1  frame-start pulse from upstream
- `res_e`  in  1  `res` is valid this cycle
- `res`  in  `FM_DEPTH` x `DATA_WIDTH` signed  pooled residual vector
- `conv_e`  in  1  `conv_in` is valid this cycle (decoder strobe)
- `conv_in`  in  `FM_DEPTH` x `DATA_WIDTH` signed  decoded macro result
- `param_we`  in  1  parameter write strobe
- `param_ch`  in  $clog2(`FM_DEPTH`)  channel to write
- `param_k`, `param_b`  in  `DATA_WIDTH` signed  scale and bias
- `data_out`  out  `FM_DEPTH` x `DATA_WIDTH` signed  result vector
- `data_e_out`  out  1  `data_out` is valid (one-cycle pulse)
- `vs_out`  out  1  frame-start pulse for the next layer
- `ovf_err`, `unf_err`  out  1  sticky FIFO overflow and underflow flags

## Operation
- **Parameter storage:** per-channel `k[ch]` and `b[ch]` registers.
  - On `rst`: `k = 1 << FRAC_BITS` (256), `b = 0`.
  - When `mode == 0` and `param_we == 1`: write the channel at `param_ch`.
  - `param_we` is ignored when `mode == 1`.
- **Residual FIFO:**
  - Push on `res_e && mode`.
  - Pop on `conv_e && mode`.
  - Vectors are matched to convolution results strictly in arrival order.
- **FIFO boundary rules:**
  - Push and pop in the same cycle while empty: the incoming `res` bypasses the FIFO directly to the pop. Occupancy stays 0.
  - Push and pop in the same cycle while full: both happen. Occupancy is unchanged.
  - Push while full with no pop: the vector is dropped and `ovf_err` is set.
  - Pop while empty with no push: the residual is taken as 0 and `unf_err` is set.
  - `ovf_err` and `unf_err` are cleared only by `rst`.
- **Arithmetic, stage 1:**
  - `prod = conv_in * k`, 32-bit signed.
  - `scaled = prod >>> FRAC_BITS` (arithmetic shift, truncating toward -inf), kept at 24 bits.
  - The popped `res` is registered alongside.
- **Arithmetic, stage 2:**
  - `sum = scaled + b + res` at 26-bit signed.
  - Saturate to [-32768, 32767] and register into `data_out`.
- **`vs_in` (in any mode):**
  - Synchronously empties the FIFO.
  - Clears both pipeline valid bits, discarding in-flight vectors.
  - Produces `vs_out` 2 cycles later.
- **`mode` falling to 0:**
  - Clears the pipeline valid bits.
  - The FIFO contents are kept.
  - `data_out` holds its last value.
- **`rst`:** clears the FIFO, valid bits, `data_out`, `vs_out` and both error flags.

## Timing
- Reset values: `data_out = 0`, `data_e_out = 0`, `vs_out = 0`, `ovf_err = 0`, `unf_err = 0`.
- Latency is 2 cycles, fixed:
  - `conv_e` at cycle t gives `data_e_out = 1` at t+2.
  - `vs_in` at cycle t gives `vs_out = 1` at t+2.
- Throughput is one vector per cycle. There is no backpressure: the downstream stage must accept every `data_e_out` pulse.
- `data_out` holds between pulses.
- When `vs_in` and `conv_e` occur in the same cycle, `vs_in` wins: that `conv_e` is discarded.
- A parameter write at cycle t is used by any `conv_e` at t+1 or later.

## Structure
- Shared package `bn_res_pkg` holds:
  - `DATA_WIDTH`, `FRAC_BITS`, `PROD_WIDTH = 32`, `SUM_WIDTH = 26`
  - the `sat16` function
  - the typedef `sample_t` (signed `DATA_WIDTH`)
- One sub-module, `res_fifo`, parameterised by depth and vector width. It provides:
  - the bypass and full/empty logic
  - `push_drop` and `pop_empty` strobes, which feed the sticky error flags
- The top level holds the parameter registers, the 2-stage datapath (generated per channel) and the `vs` delay.

## Test plan
- **Reset and defaults:** after `rst`, with no parameter writes, `res = 10`, `conv_in = 100`, `res_e` then `conv_e` → `data_out = 110` at `conv_e` + 2; before that, all outputs are 0.
- **Parameter load:** in `mode = 0`, write channel 5 with `k = 128`, `b = -20`; then `conv_in = 200`, `res = 7` → channel 5 gives `data_out = 87`, and the other channels use the default parameters.
- **Saturation:** `k = 32767`, `conv_in = 32767`, `b = 32767` → 32767; `conv_in = -32768` with `k = 32767` → -32768.
- **FIFO boundaries:**
  - 5 `res_e` pulses with no `conv_e` → `ovf_err = 1`; the next 4 `conv_e` pulses use residuals 1 to 4, and the 5th is dropped.
  - `conv_e` on an empty FIFO → residual 0 and `unf_err = 1`.
  - Simultaneous push and pop while empty → the bypassed `res` is used.
- **Frame and mode events:**
  - `vs_in` with 2 vectors in flight → no `data_e_out` for them, and `vs_out` at +2.
  - `mode` dropped to 0 mid-stream → no pulses, and `data_out` held.
